// File: rtl/seq_mult_param.sv
// Parametrised shift-add sequential multiplier, one multiplier bit retired per clock.
// Optional signed operation is enabled by defining SEQ_MULT_SIGNED_EN.
module seq_mult_param #(
   parameter int WIDTH      = 16,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start_valid,
   output logic               start_ready,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   input  logic               signed_mode,
   output logic               result_valid,
   input  logic               result_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_reg;
   logic [PW-1:0]     mcand_sh_reg;
   logic [WIDTH-1:0]  mplier_sh_reg;
   logic [PW-1:0]     acc_reg;
   logic [CW-1:0]     count_reg;
   logic [PW-1:0]     product_reg;
   logic              start_ready_reg;
   logic              result_valid_reg;
   logic              busy_reg;
   logic              neg_reg;

   logic [WIDTH-1:0]  a_mag;
   logic [WIDTH-1:0]  b_mag;
   logic              neg_in;
   logic [PW-1:0]     acc_sum;
   logic [WIDTH-1:0]  mplier_next;
   logic [CW-1:0]     count_next;
   logic              finish;
   logic [PW-1:0]     final_val;

`ifdef SEQ_MULT_SIGNED_EN
   // Magnitudes fit in WIDTH bits unsigned, including the most negative operand.
   logic neg_a;
   logic neg_b;
   always_comb begin
      neg_a  = signed_mode & multiplicand[WIDTH-1];
      neg_b  = signed_mode & multiplier[WIDTH-1];
      a_mag  = neg_a ? (~multiplicand + 1'b1) : multiplicand;
      b_mag  = neg_b ? (~multiplier + 1'b1) : multiplier;
      neg_in = neg_a ^ neg_b;
   end
`else
   logic unused_signed_mode;
   assign unused_signed_mode = signed_mode;
   always_comb begin
      a_mag  = multiplicand;
      b_mag  = multiplier;
      neg_in = 1'b0;
   end
`endif

   always_comb begin
      acc_sum     = acc_reg + (mplier_sh_reg[0] ? mcand_sh_reg : '0);
      mplier_next = mplier_sh_reg >> 1;
      count_next  = count_reg + CW'(1);
      finish      = (count_next == CW'(WIDTH)) || (EARLY_EXIT && (mplier_next == '0));
`ifdef SEQ_MULT_SIGNED_EN
      final_val   = neg_reg ? (~acc_sum + 1'b1) : acc_sum;
`else
      final_val   = acc_sum;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg        <= IDLE;
         mcand_sh_reg     <= '0;
         mplier_sh_reg    <= '0;
         acc_reg          <= '0;
         count_reg        <= '0;
         product_reg      <= '0;
         neg_reg          <= 1'b0;
         start_ready_reg  <= 1'b1;
         result_valid_reg <= 1'b0;
         busy_reg         <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start_valid) begin
                  mcand_sh_reg    <= {{WIDTH{1'b0}}, a_mag};
                  mplier_sh_reg   <= b_mag;
                  acc_reg         <= '0;
                  count_reg       <= '0;
                  neg_reg         <= neg_in;
                  start_ready_reg <= 1'b0;
                  busy_reg        <= 1'b1;
                  // A zero multiplier has nothing to retire, so skip RUN entirely.
                  if (EARLY_EXIT && (b_mag == '0)) begin
                     product_reg      <= '0;
                     result_valid_reg <= 1'b1;
                     state_reg        <= DONE;
                  end else begin
                     state_reg <= RUN;
                  end
               end
            end
            RUN: begin
               acc_reg       <= acc_sum;
               mcand_sh_reg  <= mcand_sh_reg << 1;
               mplier_sh_reg <= mplier_next;
               count_reg     <= count_next;
               if (finish) begin
                  product_reg      <= final_val;
                  result_valid_reg <= 1'b1;
                  state_reg        <= DONE;
               end
            end
            DONE: begin
               if (result_ready) begin
                  result_valid_reg <= 1'b0;
                  start_ready_reg  <= 1'b1;
                  busy_reg         <= 1'b0;
                  state_reg        <= IDLE;
               end
            end
            default: begin
               state_reg        <= IDLE;
               start_ready_reg  <= 1'b1;
               result_valid_reg <= 1'b0;
               busy_reg         <= 1'b0;
            end
         endcase
      end
   end

   assign start_ready  = start_ready_reg;
   assign result_valid = result_valid_reg;
   assign busy         = busy_reg;
   assign product      = product_reg;

endmodule

// File: doc/seq_mult_param.md
Name: seq_mult_param

Overview:
Parametrised shift-add sequential multiplier. One multiplier bit is retired per clock.
- Operands are accepted through a valid/ready start handshake; the result is returned through a valid/ready result handshake.
- Generalises the fixed 16-bit datapath to any operand width, with optional early termination and optional signed operation.
- Sits between the operand-issue control and any downstream consumer of 2*WIDTH-bit products.

Parameters:
WIDTH, 16, operand width in bits (>= 2); product is 2*WIDTH bits.
EARLY_EXIT, 1, 1 = finish as soon as the remaining multiplier bits are all zero; 0 = always run WIDTH iterations.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high; returns block to IDLE.
start_valid  input  1  operands present.
start_ready  output  1  block can accept operands (high only in IDLE).
multiplicand  input  WIDTH  operand A, sampled on accept.
multiplier  input  WIDTH  operand B, sampled on accept.
signed_mode  input  1  operands are two's complement (honoured only with SEQ_MULT_SIGNED_EN).
result_valid  output  1  product valid (high only in DONE).
result_ready  input  1  consumer takes product.
product  output  2*WIDTH  registered result.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset values: state=IDLE, start_ready=1, result_valid=0, busy=0, product=0. Internal accumulator, shift registers and counter (width $clog2(WIDTH+1)) are all cleared.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately. No partial result is ever presented.

IDLE:
- Accept on start_valid & start_ready.
- On accept, load mcand_sh (2*WIDTH bits, zero-extended), load mplier_sh, clear acc and count.
- Go to RUN. Exception: EARLY_EXIT=1 and multiplier==0 go straight to DONE with product=0 (latency 1).

RUN, each edge:
- If mplier_sh[0], then acc <= acc + mcand_sh (modulo 2^(2*WIDTH); cannot overflow for unsigned operands).
- mcand_sh <<= 1; mplier_sh >>= 1; count++.
- Go to DONE when count reaches WIDTH, or, if EARLY_EXIT=1, when the post-shift mplier_sh==0.
- On that same edge product <= final acc (after any sign fix-up).
- start_valid is ignored in RUN.

Latency:
- Measured from the accept edge to the first cycle with result_valid high.
- EARLY_EXIT=0: exactly WIDTH cycles.
- EARLY_EXIT=1: max(1, msb_index(multiplier)+1) cycles.

DONE:
- result_valid=1; product stays stable while result_ready is low.
- On result_valid & result_ready, go to IDLE; start_ready rises the following cycle.
- No back-to-back accept in DONE.
- product holds its last value in IDLE until the next DONE entry.

Optional Feature:
Macro SEQ_MULT_SIGNED_EN.

Defined:
- When signed_mode=1 on accept, operands are converted to magnitudes (|-2^(WIDTH-1)| = 2^(WIDTH-1) fits unsigned) and multiplied unsigned.
- The sign bit is latched as negA^negB.
- On DONE entry the product is two's-complement negated if that sign bit is set.
- Latency is unchanged (early exit uses the magnitude).
- signed_mode=0 gives unsigned behaviour.

Not defined:
- signed_mode is ignored and all operations are unsigned.
- No magnitude or negate logic is synthesised.

Test Plan:
1. WIDTH=16, A=3, B=5, EARLY_EXIT=0 -> product=0x0000000F, result_valid 16 cycles after accept. Same with EARLY_EXIT=1 -> result_valid after 3 cycles.
2. A=0xFFFF, B=0xFFFF, unsigned -> product=0xFFFE0001 after 16 cycles; start_ready=0 throughout RUN/DONE.
3. EARLY_EXIT=1, A=0x1234, B=0 -> product=0, result_valid 1 cycle after accept. Then B=0x8000, A=1 -> product=0x00008000 after 16 cycles.
4. Backpressure: hold result_ready=0 for 5 cycles in DONE while pulsing start_valid -> product unchanged, no accept. Assert result_ready -> IDLE, start_ready=1 next cycle.
5. Assert reset at cycle 7 of RUN (A=0xAAAA, B=0xFFFF) -> all outputs at reset values immediately. Then A=7, B=9 -> product=63.
6. Macro on, signed_mode=1: A=0xFFFD (-3), B=5 -> 0xFFFFFFF1. A=B=0x8000 -> 0x40000000. Macro off, same first operands -> 0x0004FFF1.
